// File: rtl/count_job_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// count_job_arbiter_pkg : shared FSM encoding and default widths
// Revision: 1.0
// ============================================================================
package count_job_arbiter_pkg;

  localparam int C_CW_DEFAULT = 4;
  localparam int C_SW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/count_job_arbiter_udc.sv
`default_nettype none
// ============================================================================
// udc_core : wrapping up/down counter, steps only when enabled
// Revision: 1.0
// ============================================================================
module udc_core
  import count_job_arbiter_pkg::*;
#(
  parameter int CW = C_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          up,
  output logic [CW-1:0] q
);

  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= up ? (r_q + C_ONE) : (r_q - C_ONE);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/count_job_arbiter.sv
`default_nettype none
// ============================================================================
// count_job_arbiter : two-requester round-robin arbiter driving a shared
//                     up/down step counter, one job at a time
// Revision: 1.0
// ============================================================================
module count_job_arbiter
  import count_job_arbiter_pkg::*;
#(
  parameter int CW = C_CW_DEFAULT,
  parameter int SW = C_SW_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_dir,
  input  logic [2*SW-1:0] req_steps,
  output logic [1:0]      req_ready,
  output logic [CW-1:0]   cnt_out,
  output logic            busy,
  output logic            owner,
  output logic            done_valid,
  output logic            done_id,
  output logic [CW-1:0]   done_value
);

  localparam logic [SW-1:0] C_STEP_ONE = SW'(1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_dir;
  logic [SW-1:0] r_steps;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_done_valid;
  logic          r_done_id;
  logic [CW-1:0] r_done_value;

  logic [1:0]    w_ready;
  logic          w_grant_idx;
  logic          w_accept;
  logic [SW-1:0] w_sel_steps;
  logic          w_sel_dir;
  logic          w_cnt_en;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_id;

  // Grant is only offered in IDLE; a tie goes to whoever did not own the last job.
  always_comb begin
    w_ready     = 2'b00;
    w_grant_idx = 1'b0;
    if (rstn && (r_state == ST_IDLE)) begin
      case (req_valid)
        2'b01: begin
          w_ready     = 2'b01;
          w_grant_idx = 1'b0;
        end
        2'b10: begin
          w_ready     = 2'b10;
          w_grant_idx = 1'b1;
        end
        2'b11: begin
          w_grant_idx = ~r_last_owner;
          w_ready     = r_last_owner ? 2'b01 : 2'b10;
        end
        default: begin
          w_ready     = 2'b00;
          w_grant_idx = 1'b0;
        end
      endcase
    end
  end

  assign w_accept    = |(req_valid & w_ready);
  assign w_sel_steps = w_grant_idx ? req_steps[2*SW-1:SW] : req_steps[SW-1:0];
  assign w_sel_dir   = req_dir[w_grant_idx];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_sel_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (r_steps == C_STEP_ONE) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cnt_en = (r_state == ST_RUN);

  // Counter value after this edge, so done_value is valid in the DONE cycle itself.
  assign w_cnt_nxt = w_cnt_en ? (r_dir ? (w_cnt + C_CNT_ONE) : (w_cnt - C_CNT_ONE)) : w_cnt;
  assign w_done_id = (r_state == ST_IDLE) ? w_grant_idx : r_owner;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_dir        <= 1'b0;
      r_steps      <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_done_valid <= 1'b0;
      r_done_id    <= 1'b0;
      r_done_value <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_dir   <= w_sel_dir;
        r_steps <= w_sel_steps;
        r_owner <= w_grant_idx;
      end else if (r_state == ST_RUN) begin
        r_steps <= r_steps - C_STEP_ONE;
      end
      if (w_state_nxt == ST_DONE) begin
        r_done_id    <= w_done_id;
        r_done_value <= w_cnt_nxt;
      end
      if (r_state == ST_DONE) begin
        r_last_owner <= r_owner;
      end
    end
  end

  udc_core #(
    .CW (CW)
  ) u_udc_core (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_cnt_en),
    .up   (r_dir),
    .q    (w_cnt)
  );

  assign req_ready  = w_ready;
  assign cnt_out    = w_cnt;
  assign busy       = (r_state != ST_IDLE);
  assign owner      = r_owner;
  assign done_valid = r_done_valid;
  assign done_id    = r_done_id;
  assign done_value = r_done_value;

endmodule
`default_nettype wire

// File: tb/tb_count_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_count_job_arbiter : table-driven jobs with a completion scoreboard
// Revision: 1.0
// ============================================================================
module tb_count_job_arbiter;

  localparam int CW = 4;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_dir = 2'b00;
  logic [2*SW-1:0] req_steps = '0;
  logic [1:0]      req_ready;
  logic [CW-1:0]   cnt_out;
  logic            busy;
  logic            owner;
  logic            done_valid;
  logic            done_id;
  logic [CW-1:0]   done_value;

  count_job_arbiter #(.CW(CW), .SW(SW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_steps  (req_steps),
    .req_ready  (req_ready),
    .cnt_out    (cnt_out),
    .busy       (busy),
    .owner      (owner),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_value (done_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [CW-1:0] value;
  } done_t;

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    dir;
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
    logic [1:0]    exp_ready;
  } vec_t;

  done_t         sb_q[$];
  done_t         mon_e;
  vec_t          vecs[15];
  vec_t          post_vec;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_cnt;
  logic          m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expected job.
  always @(negedge clk) begin
    if (rstn && (req_valid == 2'b11)) begin
      check("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
    end
    if (done_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: actual id=%0d value=%0d required=no pulse", done_id, done_value);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_id", 32'(done_id), 32'(mon_e.id));
        check("done_value", 32'(done_value), 32'(mon_e.value));
      end
    end
  end

  // Entered at a negedge in IDLE; leaves at the negedge of the first IDLE cycle after DONE.
  task automatic run_vec(input vec_t v, input bit hold_valid);
    logic          g;
    logic          d;
    int            n;
    logic [CW-1:0] fin;
    req_valid = v.valid;
    req_dir   = v.dir;
    req_steps = {v.s1, v.s0};
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("req_ready", 32'(req_ready), 32'(v.exp_ready));
    if (v.valid == 2'b00) begin
      @(posedge clk);
      #1;
      check("no_job_busy", 32'(busy), 32'd0);
      @(negedge clk);
      return;
    end
    g = (v.valid == 2'b11) ? ~m_last : v.valid[1];
    n = g ? int'(v.s1) : int'(v.s0);
    d = v.dir[g];
    fin = m_cnt;
    for (int k = 0; k < n; k++) fin = d ? fin + 1'b1 : fin - 1'b1;
    sb_q.push_back('{id: g, value: fin});
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = 2'b00;
    req_dir   = 2'($urandom);
    req_steps = (2*SW)'($urandom);
    check("job_busy", 32'(busy), 32'd1);
    check("job_owner", 32'(owner), 32'(g));
    check("cnt_hold_at_accept", 32'(cnt_out), 32'(m_cnt));
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      m_cnt = d ? m_cnt + 1'b1 : m_cnt - 1'b1;
      check("cnt_step", 32'(cnt_out), 32'(m_cnt));
    end
    check("done_pulse", 32'(done_valid), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("idle_after_done", 32'(busy), 32'd0);
    check("done_single", 32'(done_valid), 32'd0);
    m_last = g;
    @(negedge clk);
  endtask

  initial begin
    // valid, dir, s0, s1, expected req_ready
    vecs[0]  = '{2'b01, 2'b01, 4'd5, 4'd0, 2'b01};
    vecs[1]  = '{2'b01, 2'b01, 4'd9, 4'd0, 2'b01};
    vecs[2]  = '{2'b10, 2'b10, 4'd0, 4'd3, 2'b10};
    vecs[3]  = '{2'b10, 2'b00, 4'd0, 4'd3, 2'b10};
    vecs[4]  = '{2'b11, 2'b01, 4'd2, 4'd1, 2'b01};
    vecs[5]  = '{2'b11, 2'b01, 4'd2, 4'd1, 2'b10};
    vecs[6]  = '{2'b11, 2'b01, 4'd2, 4'd1, 2'b01};
    vecs[7]  = '{2'b11, 2'b01, 4'd2, 4'd1, 2'b10};
    vecs[8]  = '{2'b01, 2'b01, 4'd7, 4'd0, 2'b01};
    vecs[9]  = '{2'b01, 2'b00, 4'd0, 4'd0, 2'b01};
    vecs[10] = '{2'b10, 2'b10, 4'd0, 4'd2, 2'b10};
    vecs[11] = '{2'b10, 2'b10, 4'd0, 4'd2, 2'b10};
    vecs[12] = '{2'b10, 2'b10, 4'd0, 4'd2, 2'b10};
    vecs[13] = '{2'b00, 2'b00, 4'd0, 4'd0, 2'b00};
    vecs[14] = '{2'b11, 2'b11, 4'd1, 4'd1, 2'b01};
    post_vec = '{2'b11, 2'b00, 4'd3, 4'd4, 2'b01};
    m_cnt  = '0;
    m_last = 1'b1;

    rstn      = 1'b0;
    req_valid = 2'b11;
    req_steps = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_cnt", 32'(cnt_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_done_value", 32'(done_value), 32'd0);
    rstn      = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], vecs[i].valid == 2'b11);

    // Reset in the middle of an 8-step job aborts it silently.
    req_valid = 2'b01;
    req_dir   = 2'b01;
    req_steps = {4'd0, 4'd8};
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (3) begin
      @(posedge clk);
      #1;
      m_cnt = m_cnt + 1'b1;
    end
    check("abort_cnt_before", 32'(cnt_out), 32'(m_cnt));
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = 2'b01;
    #1;
    check("abort_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("abort_cnt", 32'(cnt_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    rstn      = 1'b1;
    req_valid = 2'b00;
    m_cnt     = '0;
    m_last    = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    run_vec(post_vec, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
